// File: rtl/button_event_arbiter_pkg.sv
// Shared event-kind codes and channel state encodings for the button event arbiter.
package button_event_arbiter_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'b00;
  localparam logic [1:0] KIND_REPEAT  = 2'b01;
  localparam logic [1:0] KIND_RELEASE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } ch_state_e;

endpackage

// File: rtl/button_event_channel.sv
// One button channel: edge detect, press/hold/repeat FSM, hold timer and a single pending event slot.
module button_event_channel
  import button_event_arbiter_pkg::*;
#(
  parameter int CNT_W         = 26,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       grant,
  output logic       slot_valid,
  output logic [1:0] slot_kind,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             prev_q;
  logic             slot_valid_q, slot_valid_d;
  logic [1:0]       slot_kind_q, slot_kind_d;
  logic             rise, fall, post;
  logic [1:0]       post_kind;

  always_comb begin
    rise      = btn & ~prev_q;
    fall      = ~btn & prev_q;
    state_d   = state_q;
    timer_d   = timer_q;
    post      = 1'b0;
    post_kind = KIND_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d   = ST_HELD;
          timer_d   = '0;
          post      = 1'b1;
          post_kind = KIND_PRESS;
        end
      end
      ST_HELD, ST_RPT: begin
        // A release on the threshold cycle suppresses that REPEAT.
        if (fall) begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          post      = 1'b1;
          post_kind = KIND_RELEASE;
        end else if (timer_q == ((state_q == ST_HELD) ? HOLD_LAST : REPEAT_LAST)) begin
          state_d   = ST_RPT;
          timer_d   = '0;
          post      = 1'b1;
          post_kind = KIND_REPEAT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    slot_valid_d = slot_valid_q & ~grant;
    slot_kind_d  = slot_kind_q;
    ovf          = 1'b0;
    if (post) begin
      if (!slot_valid_d) begin
        slot_valid_d = 1'b1;
        slot_kind_d  = post_kind;
      end else if (post_kind != KIND_REPEAT) begin
        // An undelivered PRESS/RELEASE is lost; a late REPEAT is simply dropped.
        slot_kind_d = post_kind;
        ovf         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      prev_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_kind_q  <= KIND_PRESS;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      prev_q       <= btn;
      slot_valid_q <= slot_valid_d;
      slot_kind_q  <= slot_kind_d;
    end
  end

  assign slot_valid = slot_valid_q;
  assign slot_kind  = slot_kind_q;

endmodule

// File: rtl/button_event_arbiter.sv
// Per-button event channels merged round-robin onto one valid/ready event port with a sticky overflow flag.
module button_event_arbiter
  import button_event_arbiter_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int ID_W          = 2,
  parameter int CNT_W         = 26,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_kind,
  output logic [N_BTN-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic [N_BTN-1:0] slot_valid;
  logic [1:0]       slot_kind [N_BTN];
  logic [N_BTN-1:0] ovf_vec;
  logic [N_BTN-1:0] grant;

  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic [1:0]       evt_kind_q, evt_kind_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             overflow_q, overflow_d;

  logic             load_en, found;
  logic [ID_W-1:0]  gnt_idx;
  int               cand_idx;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
      button_event_channel #(
        .CNT_W         (CNT_W),
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn_level[gi]),
        .grant      (grant[gi]),
        .slot_valid (slot_valid[gi]),
        .slot_kind  (slot_kind[gi]),
        .ovf        (ovf_vec[gi])
      );
    end
  endgenerate

  // First pending slot at or after the round-robin pointer.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    cand_idx = 0;
    for (int off = 0; off < N_BTN; off++) begin
      cand_idx = (int'(rr_ptr_q) + off) % N_BTN;
      if (!found && slot_valid[cand_idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(cand_idx);
      end
    end
  end

  always_comb begin
    load_en     = ~evt_valid_q | evt_ready;
    grant       = '0;
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_kind_d  = evt_kind_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (found) begin
        grant[gnt_idx] = 1'b1;
        evt_valid_d    = 1'b1;
        evt_id_d       = gnt_idx;
        evt_kind_d     = slot_kind[gnt_idx];
        rr_ptr_d       = (gnt_idx == ID_W'(N_BTN - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    overflow_d = (overflow_q & ~clr_ovf) | (|ovf_vec);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_kind_q  <= KIND_PRESS;
      rr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_kind_q  <= evt_kind_d;
      rr_ptr_q    <= rr_ptr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_kind_q;
  assign pending   = slot_valid;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with HOLD=8, REPEAT=4; accepted events are logged and checked in order.
module tb_button_event_arbiter;

  localparam int N_BTN = 4;
  localparam int ID_W  = 2;

  localparam int K_PRESS   = 0;
  localparam int K_REPEAT  = 1;
  localparam int K_RELEASE = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_level;
  logic             evt_valid;
  logic             evt_ready;
  logic [ID_W-1:0]  evt_id;
  logic [1:0]       evt_kind;
  logic [N_BTN-1:0] pending;
  logic             overflow;
  logic             clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int cyc;
    int id;
    int kind;
  } evt_t;
  evt_t evt_q[$];

  button_event_arbiter #(
    .N_BTN         (N_BTN),
    .ID_W          (ID_W),
    .CNT_W         (26),
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_kind  (evt_kind),
    .pending   (pending),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      evt_t e;
      e.cyc  = cyc;
      e.id   = int'(evt_id);
      e.kind = int'(evt_kind);
      evt_q.push_back(e);
      $display("evt cyc=%0d id=%0d kind=%0d", e.cyc, e.id, e.kind);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input string tag, input int id, input int kind, output int c);
    int n;
    n = 0;
    while (evt_q.size() == 0 && n < 50) begin
      tick();
      n++;
    end
    if (evt_q.size() == 0) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      c = 0;
    end else begin
      evt_t e;
      e = evt_q.pop_front();
      check({tag, "_id"}, e.id, id);
      check({tag, "_kind"}, e.kind, kind);
      c = e.cyc;
    end
  endtask

  initial begin
    int c0, c1, c2, c3, c4;
    rst       = 1'b1;
    btn_level = '0;
    evt_ready = 1'b1;
    clr_ovf   = 1'b0;

    // 1. Reset state, then a button held through reset deassert
    repeat (3) tick();
    check("rst_valid", evt_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    btn_level = 4'b0100;
    tick();
    rst = 1'b0;
    tick();
    check("held_rst_pending", pending, 4'b0100);
    check("held_rst_valid_early", evt_valid, 0);
    tick();
    check("held_rst_valid", evt_valid, 1);
    check("held_rst_id", evt_id, 2);
    check("held_rst_kind", evt_kind, K_PRESS);
    expect_evt("held_rst_press", 2, K_PRESS, c0);
    btn_level = 4'b0000;
    expect_evt("held_rst_release", 2, K_RELEASE, c0);
    repeat (3) tick();

    // 2. Single tap: one-cycle PRESS then one-cycle RELEASE
    btn_level = 4'b0100;
    tick();
    tick();
    check("tap_press_valid", evt_valid, 1);
    check("tap_press_kind", evt_kind, K_PRESS);
    tick();
    check("tap_press_one_cycle", evt_valid, 0);
    btn_level = 4'b0000;
    tick();
    check("tap_gap_valid", evt_valid, 0);
    tick();
    check("tap_release_valid", evt_valid, 1);
    check("tap_release_kind", evt_kind, K_RELEASE);
    tick();
    check("tap_release_one_cycle", evt_valid, 0);
    expect_evt("tap_press", 2, K_PRESS, c0);
    expect_evt("tap_release", 2, K_RELEASE, c1);
    check("tap_delta", c1 - c0, 3);
    repeat (3) tick();

    // 3. Long press: 20 cycles held, release coincides with a repeat threshold
    btn_level = 4'b0001;
    repeat (20) tick();
    btn_level = 4'b0000;
    repeat (4) tick();
    expect_evt("long_press", 0, K_PRESS, c0);
    expect_evt("long_rpt1", 0, K_REPEAT, c1);
    check("long_rpt1_delta", c1 - c0, 8);
    expect_evt("long_rpt2", 0, K_REPEAT, c2);
    check("long_rpt2_delta", c2 - c0, 12);
    expect_evt("long_rpt3", 0, K_REPEAT, c3);
    check("long_rpt3_delta", c3 - c0, 16);
    expect_evt("long_release", 0, K_RELEASE, c4);
    check("long_release_delta", c4 - c0, 20);
    check("long_no_extra", evt_q.size(), 0);

    // 4. Simultaneous press/release on all channels from pointer 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    btn_level = 4'b1111;
    repeat (5) tick();
    btn_level = 4'b0000;
    repeat (8) tick();
    c0 = 0;
    for (int i = 0; i < N_BTN; i++) begin
      expect_evt($sformatf("all_press%0d", i), i, K_PRESS, c1);
      if (i > 0) check($sformatf("all_press%0d_delta", i), c1 - c0, 1);
      c0 = c1;
    end
    for (int i = 0; i < N_BTN; i++) begin
      expect_evt($sformatf("all_release%0d", i), i, K_RELEASE, c1);
      if (i > 0) check($sformatf("all_release%0d_delta", i), c1 - c0, 1);
      c0 = c1;
    end
    check("all_no_extra", evt_q.size(), 0);

    // 5. Backpressure, slot overwrite and overflow
    evt_ready = 1'b0;
    btn_level = 4'b0010;
    tick();
    tick();
    btn_level = 4'b0000;
    tick();
    check("bp_valid", evt_valid, 1);
    check("bp_id", evt_id, 1);
    check("bp_kind", evt_kind, K_PRESS);
    check("bp_pending", pending, 4'b0010);
    check("bp_overflow0", overflow, 0);
    btn_level = 4'b0010;
    tick();
    check("bp_overflow1", overflow, 1);
    check("bp_pending_kept", pending, 4'b0010);
    check("bp_hold_kind", evt_kind, K_PRESS);
    evt_ready = 1'b1;
    tick();
    check("bp_reload_valid", evt_valid, 1);
    check("bp_reload_pending", pending, 0);
    tick();
    btn_level = 4'b0000;
    expect_evt("bp_press_a", 1, K_PRESS, c0);
    expect_evt("bp_press_b", 1, K_PRESS, c1);
    expect_evt("bp_release", 1, K_RELEASE, c2);
    check("bp_overflow_sticky", overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("bp_overflow_clr", overflow, 0);
    repeat (3) tick();

    // 6. Reset in the middle of auto-repeat
    btn_level = 4'b1000;
    repeat (11) tick();
    expect_evt("rr_press", 3, K_PRESS, c0);
    expect_evt("rr_rpt", 3, K_REPEAT, c1);
    check("rr_rpt_delta", c1 - c0, 8);
    rst = 1'b1;
    tick();
    check("rr_rst_valid", evt_valid, 0);
    check("rr_rst_pending", pending, 0);
    check("rr_rst_overflow", overflow, 0);
    check("rr_rst_id", evt_id, 0);
    check("rr_rst_kind", evt_kind, 0);
    rst = 1'b0;
    expect_evt("rr_fresh_press", 3, K_PRESS, c2);
    expect_evt("rr_fresh_rpt", 3, K_REPEAT, c3);
    check("rr_fresh_rpt_delta", c3 - c2, 8);
    btn_level = 4'b0000;
    expect_evt("rr_release", 3, K_RELEASE, c4);
    repeat (4) tick();
    check("rr_no_extra", evt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
